flash_clkrst_retimer: RTL
=========================

Name: flash_clkrst_retimer

Overview:
Parametrised successor to the fixed 6+3 flash clock/reset buffer. It carries N_S signals north-to-south and N_N signals south-to-north through a configurable number of retiming register stages. One southbound channel is designated as the flash-domain reset, and a hold-off state machine stretches its release. The block sits between the housekeeping/flash controller and the pad-side flash interface. Everything is clocked by the Wishbone clock.

Parameters:
N_S, 6, number of north-to-south channels (in_n -> out_s), 1..32
N_N, 3, number of south-to-north channels (in_s -> out_n), 1..32
STAGES, 2, retiming register depth per channel, 0..4; 0 = combinational pass
RST_IDX, 0, index in in_n/out_s of the flash reset channel (active-high), < N_S
RST_HOLD, 16, cycles the reset output stays asserted after its source releases, 1..255

Ports:
wb_clk_i  input  1  block clock
wb_rst_i  input  1  synchronous, active-high reset
in_n  input  N_S  signals from the north (controller side)
in_s  input  N_N  signals from the south (pad side)
out_s  output  N_S  retimed in_n to the south; bit RST_IDX is the stretched reset
out_n  output  N_N  retimed in_s to the north
bypass_i  input  1  1 = skip retiming; out_s/out_n take in_n/in_s combinationally, reset stretcher still active
pipe_valid_o  output  1  1 once the retiming pipeline holds post-reset data
rst_busy_o  output  1  1 while the stretched reset output is asserted

Behaviour:
- One clock, wb_clk_i; reset is synchronous and active-high on wb_rst_i. No other clocks and no asynchronous logic.
- Retiming: each channel is a shift register of STAGES flops. Latency is exactly STAGES cycles from input to output. STAGES=0 is a wire.
- Reset values: all pipeline flops = 0; out_s = 0 except out_s[RST_IDX] = 1; out_n = 0; pipe_valid_o = 0; rst_busy_o = 1.
- pipe_valid_o: a fill counter counts cycles after wb_rst_i deasserts. pipe_valid_o goes high on the STAGES-th rising edge after reset release, or on the first edge if STAGES=0. It stays high until the next reset and is unaffected by bypass_i.
- Reset source: src = (in_n[RST_IDX] after retiming, i.e. the pipeline output, or the raw input when bypass_i=1) OR wb_rst_i.
- Reset stretcher FSM, 2-bit state, counter width 8:
  - ASSERT: out_s[RST_IDX]=1, rst_busy_o=1. When src=0, load count=RST_HOLD-1 and go to HOLD.
  - HOLD: out_s[RST_IDX]=1, rst_busy_o=1. If src=1, go back to ASSERT. Else if count=0, go to RELEASED. Else decrement count.
  - RELEASED: out_s[RST_IDX]=0, rst_busy_o=0. If src=1, go to ASSERT.
  - out_s[RST_IDX] is registered from the FSM, so assertion appears one cycle after src rises.
  - Total release delay from src falling to out_s[RST_IDX] falling is RST_HOLD+1 cycles.
  - wb_rst_i forces the FSM to ASSERT.
- Boundary conditions:
  - src re-asserted during HOLD restarts the full hold on the next release; no partial credit.
  - A 1-cycle src pulse in RELEASED still produces a full ASSERT plus RST_HOLD-cycle HOLD.
  - bypass_i toggling mid-stream switches the output source on the same cycle. Pipeline flops keep shifting, so data is continuous when switching back after at least STAGES cycles.
  - Reset applied mid-operation clears the pipeline. No stale data appears after reset.
  - Non-reset channels never pass through the FSM.

Optional Feature:
FLASH_CLKRST_GLITCH_FILTER_EN.
- Defined: each in_s bit passes through a 2-sample agreement filter before the retiming pipeline. The filtered value updates only when two consecutive samples are equal; otherwise it holds. This adds 2 cycles of latency to out_n, which is STAGES+2, also in bypass. The filter resets to 0.
- Undefined: no filter; out_n latency is STAGES. The in_n path is never filtered.

Test Plan:
1. STAGES=2, N_S=6, N_N=3, release reset, drive in_n=6'h2A, in_s=3'h5 -> out_s[5:1] = 5'b10101 and out_n=3'h5 exactly 2 cycles later; pipe_valid_o rises on the 2nd edge after release.
2. RST_HOLD=16, in_n[0] held 1 then dropped at cycle T -> out_s[0] and rst_busy_o fall at T+2+17 (pipeline plus stretch).
3. During HOLD with count=5, pulse in_n[0] for 1 cycle -> FSM returns to ASSERT and out_s[0] stays 1 for a full 16-cycle hold after the pulse ends.
4. bypass_i=1 with STAGES=3 -> out_s/out_n follow inputs in the same cycle. Deassert bypass_i after 3 or more cycles -> outputs show the pipelined value with no gap.
5. Assert wb_rst_i mid-traffic -> on the next edge out_n=0, out_s=0 except bit RST_IDX=1, and pipe_valid_o=0, rst_busy_o=1.
6. With FLASH_CLKRST_GLITCH_FILTER_EN defined, drive a 1-cycle glitch on in_s[1] -> out_n[1] unchanged. A 2-cycle level change appears at out_n after STAGES+2 cycles.

Source files
------------

// File: rtl/flash_clkrst_retimer.sv
`default_nettype none
// ============================================================================
//  Module      : flash_clkrst_retimer
//  Description : Retiming buffer for flash clock/reset signals. It carries N_S
//                southbound and N_N northbound channels through STAGES
//                register stages. Southbound channel RST_IDX is the
//                flash-domain reset. A hold-off FSM stretches its release.
//                Optional macro FLASH_CLKRST_GLITCH_FILTER_EN adds a
//                2-sample agreement filter on every in_s bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_clkrst_retimer #(
    parameter int N_S      = 6,
    parameter int N_N      = 3,
    parameter int STAGES   = 2,
    parameter int RST_IDX  = 0,
    parameter int RST_HOLD = 16
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic [N_S-1:0] in_n,
    input  logic [N_N-1:0] in_s,
    output logic [N_S-1:0] out_s,
    output logic [N_N-1:0] out_n,
    input  logic           bypass_i,
    output logic           pipe_valid_o,
    output logic           rst_busy_o
);

    localparam logic [7:0] C_HOLD_LOAD   = 8'(RST_HOLD - 1);
    localparam logic [2:0] C_FILL_TARGET = (STAGES == 0) ? 3'd1 : 3'(STAGES);

    typedef enum logic [1:0] {
        ST_ASSERT   = 2'd0,
        ST_HOLD     = 2'd1,
        ST_RELEASED = 2'd2
    } state_t;

    logic [N_N-1:0] w_s_in;
    logic [N_S-1:0] w_pipe_s;
    logic [N_N-1:0] w_pipe_n;
    logic           w_src;
    logic           w_rst_out;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_cnt;
    logic [7:0]     w_cnt_nxt;
    logic [2:0]     r_fill;
    logic           r_valid;

`ifdef FLASH_CLKRST_GLITCH_FILTER_EN
    logic [N_N-1:0] r_flt_prev;
    logic [N_N-1:0] r_flt_val;
    logic [N_N-1:0] w_flt_agree;

    assign w_flt_agree = ~(in_s ^ r_flt_prev);

    // Agreement filter: a bit follows the input only when two consecutive samples match
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_flt_prev <= '0;
            r_flt_val  <= '0;
        end else begin
            r_flt_prev <= in_s;
            r_flt_val  <= (in_s & w_flt_agree) | (r_flt_val & ~w_flt_agree);
        end
    end

    assign w_s_in = r_flt_val;
`else
    assign w_s_in = in_s;
`endif

    generate
        if (STAGES == 0) begin : g_wire
            assign w_pipe_s = in_n;
            assign w_pipe_n = w_s_in;
        end else begin : g_pipe
            logic [N_S-1:0] r_stg_s [STAGES];
            logic [N_N-1:0] r_stg_n [STAGES];

            // Retiming shift registers; they keep shifting even while bypassed
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_stg_s[i] <= '0;
                        r_stg_n[i] <= '0;
                    end
                end else begin
                    r_stg_s[0] <= in_n;
                    r_stg_n[0] <= w_s_in;
                    for (int i = 1; i < STAGES; i++) begin
                        r_stg_s[i] <= r_stg_s[i-1];
                        r_stg_n[i] <= r_stg_n[i-1];
                    end
                end
            end

            assign w_pipe_s = r_stg_s[STAGES-1];
            assign w_pipe_n = r_stg_n[STAGES-1];
        end
    endgenerate

    // Fill counter: flags valid once post-reset data reaches the pipeline output
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_fill  <= 3'd0;
            r_valid <= 1'b0;
        end else if (!r_valid) begin
            r_fill <= r_fill + 3'd1;
            if (r_fill + 3'd1 == C_FILL_TARGET) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign pipe_valid_o = r_valid;

    // Reset source follows the same path as the data (pipelined or bypassed)
    assign w_src = (bypass_i ? in_n[RST_IDX] : w_pipe_s[RST_IDX]) | wb_rst_i;

    // Stretcher state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_ASSERT;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stretcher next state: any src assertion restarts the full hold
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ASSERT: begin
                if (!w_src) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = C_HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (w_src) begin
                    w_state_nxt = ST_ASSERT;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_RELEASED;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_RELEASED: begin
                if (w_src) begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            default: begin
                w_state_nxt = ST_ASSERT;
            end
        endcase
    end

    assign w_rst_out  = (r_state != ST_RELEASED);
    assign rst_busy_o = w_rst_out;

    // Output select; the reset bit always comes from the stretcher
    always_comb begin
        out_s          = bypass_i ? in_n : w_pipe_s;
        out_s[RST_IDX] = w_rst_out;
        out_n          = bypass_i ? w_s_in : w_pipe_n;
    end

endmodule
`default_nettype wire
